// File: rtl/pixel_dma_pkg.sv
// Shared types and constants for the pixel stream frame DMA.
package pixel_dma_pkg;

  // Pixel data transformation applied on the way to memory.
  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_FILL = 2'd1,
    MODE_MASK = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  // Frame write sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Control slave register map (word index).
  localparam logic [1:0] REG_FRONT = 2'd0;
  localparam logic [1:0] REG_BACK  = 2'd1;
  localparam logic [1:0] REG_CTRL  = 2'd2;
  localparam logic [1:0] REG_VALUE = 2'd3;

  // Replace only the bytes of old_val selected by be with those of new_val.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pixel_dma_ctrl_regs.sv
// Control/status register file for the frame DMA: double-buffer address
// pair with deferred swap, control word, fill/mask value and frame counter.
module pixel_dma_ctrl_regs
  import pixel_dma_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int FRAME_BYTES = 640
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        slave_address,
  input  logic [3:0]        slave_byteenable,
  input  logic              slave_read,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  output logic [31:0]       slave_readdata,
  input  logic              swap,
  input  logic              frame_done,
  input  logic              busy,
  output logic [ADDR_W-1:0] front_addr,
  output logic [15:0]       stride,
  output mode_e             mode,
  output logic [15:0]       value,
  output logic              enable,
  output logic              swap_pending
);

  localparam logic [15:0] DEFAULT_STRIDE = 16'(FRAME_BYTES);

  logic [31:0] front_q, front_d;
  logic [31:0] back_q, back_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [15:0] value_q, value_d;
  logic        swap_pending_q, swap_pending_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [31:0] readdata_q, readdata_d;

  // Next-state for every register: swap, slave writes, counter, read capture.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    front_d        = front_q;
    back_d         = back_q;
    ctrl_d         = ctrl_q;
    value_d        = value_q;
    swap_pending_d = swap_pending_q;
    frame_count_d  = frame_count_q;
    readdata_d     = readdata_q;

    if (swap) begin
      front_d = back_q;
      back_d  = front_q;
    end

    // A register-0 write arriving with a completing swap re-arms the next swap.
    swap_pending_d = (swap_pending_q & ~swap) | (slave_write && slave_address == REG_FRONT);

    if (slave_write) begin
      case (slave_address)
        REG_BACK:  back_d = merge_bytes(back_d, slave_writedata, slave_byteenable);
        REG_CTRL:  ctrl_d = merge_bytes(ctrl_q, slave_writedata, slave_byteenable);
        REG_VALUE: begin
          for (int i = 0; i < 2; i++) begin
            if (slave_byteenable[i]) value_d[8*i +: 8] = slave_writedata[8*i +: 8];
          end
        end
        default: ;
      endcase
    end

    if (frame_done) frame_count_d = frame_count_q + 16'd1;

    if (slave_read) begin
      case (slave_address)
        REG_FRONT: readdata_d = front_q;
        REG_BACK:  readdata_d = back_q;
        REG_CTRL:  readdata_d = ctrl_q;
        default:   readdata_d = {frame_count_q, 13'b0, swap_pending_q, busy, ctrl_q[0]};
      endcase
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      front_q        <= '0;
      back_q         <= '0;
      ctrl_q         <= '0;
      value_q        <= '0;
      swap_pending_q <= 1'b0;
      frame_count_q  <= '0;
      readdata_q     <= '0;
    end else begin
      front_q        <= front_d;
      back_q         <= back_d;
      ctrl_q         <= ctrl_d;
      value_q        <= value_d;
      swap_pending_q <= swap_pending_d;
      frame_count_q  <= frame_count_d;
      readdata_q     <= readdata_d;
    end
  end

  // Decode the control word; mode 3 behaves as pass-through.
  always_comb begin
    case (ctrl_q[2:1])
      2'd1:    mode = MODE_FILL;
      2'd2:    mode = MODE_MASK;
      default: mode = MODE_PASS;
    endcase
  end

  assign stride         = (ctrl_q[31:16] == 16'd0) ? DEFAULT_STRIDE : ctrl_q[31:16];
  assign enable         = ctrl_q[0];
  assign value          = value_q;
  assign front_addr     = ADDR_W'(front_q);
  assign swap_pending   = swap_pending_q;
  assign slave_readdata = readdata_q;

endmodule

// File: rtl/pixel_stream_frame_dma.sv
// Writes a packetised pixel stream into a frame buffer in memory, one pixel
// per beat, with SOP/EOP framing, optional fill/mask transform and
// double-buffered front/back frame addresses.
module pixel_stream_frame_dma
  import pixel_dma_pkg::*;
#(
  parameter int FRAME_W = 320,
  parameter int FRAME_H = 240,
  parameter int PIX_W   = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PIX_W-1:0]  stream_data,
  input  logic              stream_startofpacket,
  input  logic              stream_endofpacket,
  input  logic              stream_valid,
  output logic              stream_ready,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_write,
  output logic [PIX_W-1:0]  master_writedata,
  input  logic              master_waitrequest,
  input  logic [1:0]        slave_address,
  input  logic [3:0]        slave_byteenable,
  input  logic              slave_read,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  output logic [31:0]       slave_readdata,
  output logic              frame_done,
  output logic              busy
);

  localparam int BPP   = PIX_W / 8;
  localparam int XW    = $clog2(FRAME_W + 1);
  localparam int YW    = $clog2(FRAME_H + 1);
  localparam int CMP_W = (PIX_W > 16) ? PIX_W : 16;
  localparam logic [XW-1:0]     X_LAST = XW'(FRAME_W - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(FRAME_H - 1);
  localparam logic [ADDR_W-1:0] BPP_A  = ADDR_W'(BPP);

  logic [ADDR_W-1:0] front_addr;
  logic [15:0]       stride;
  mode_e             mode;
  logic [15:0]       value;
  logic              enable;
  logic              swap_pending;

  state_e            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] x_off_q, x_off_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]  data_q, data_d;
  logic              mwrite_q, mwrite_d;
  logic              frame_done_q, frame_done_d;

  logic              accept;
  logic              complete;
  logic              do_write;
  logic [XW-1:0]     wx;
  logic [YW-1:0]     wy;
  logic [ADDR_W-1:0] wx_off;
  logic [ADDR_W-1:0] wbase;
  logic [ADDR_W-1:0] stride_a;
  logic [PIX_W-1:0]  pixel_data;

  pixel_dma_ctrl_regs #(
    .ADDR_W      (ADDR_W),
    .FRAME_BYTES (FRAME_W * BPP)
  ) u_regs (
    .clk              (clk),
    .reset            (reset),
    .slave_address    (slave_address),
    .slave_byteenable (slave_byteenable),
    .slave_read       (slave_read),
    .slave_write      (slave_write),
    .slave_writedata  (slave_writedata),
    .slave_readdata   (slave_readdata),
    .swap             (complete & swap_pending),
    .frame_done       (complete),
    .busy             (busy),
    .front_addr       (front_addr),
    .stride           (stride),
    .mode             (mode),
    .value            (value),
    .enable           (enable),
    .swap_pending     (swap_pending)
  );

  // A new beat can be taken whenever the output register is empty or draining.
  assign stream_ready = enable & (~mwrite_q | ~master_waitrequest);
  assign accept       = stream_valid & stream_ready;
  assign stride_a     = ADDR_W'(stride);

  // Pixel value written to memory for the current beat.
  always_comb begin
    case (mode)
      MODE_FILL: pixel_data = PIX_W'(value);
      MODE_MASK: pixel_data = (CMP_W'(stream_data) >= CMP_W'(value)) ? '1 : '0;
      default:   pixel_data = stream_data;
    endcase
  end

  // Frame sequencer: position tracking, address generation, write hand-off.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    x_off_d      = x_off_q;
    line_base_d  = line_base_q;
    addr_d       = addr_q;
    data_d       = data_q;
    mwrite_d     = mwrite_q;
    frame_done_d = 1'b0;
    complete     = 1'b0;
    do_write     = 1'b0;
    wx           = x_q;
    wy           = y_q;
    wx_off       = x_off_q;
    wbase        = line_base_q;

    if (mwrite_q && !master_waitrequest) mwrite_d = 1'b0;

    if (accept) begin
      // SOP always (re)starts the frame at pixel (0,0).
      if (stream_startofpacket) begin
        do_write = 1'b1;
        wx       = '0;
        wy       = '0;
        wx_off   = '0;
        wbase    = '0;
      end else if (state_q == ST_RUN) begin
        do_write = 1'b1;
      end

      if (do_write) begin
        addr_d   = front_addr + wbase + wx_off;
        data_d   = pixel_data;
        mwrite_d = 1'b1;
        state_d  = ST_RUN;
        if (wx == X_LAST) begin
          x_d     = '0;
          x_off_d = '0;
          if (wy == Y_LAST) begin
            state_d     = ST_DRAIN;
            y_d         = wy;
            line_base_d = wbase;
          end else begin
            y_d         = wy + YW'(1);
            line_base_d = wbase + stride_a;
          end
        end else begin
          x_d         = wx + XW'(1);
          x_off_d     = wx_off + BPP_A;
          y_d         = wy;
          line_base_d = wbase;
        end
      end

      // EOP closes the frame only once a frame has been started.
      if (stream_endofpacket && (stream_startofpacket || state_q != ST_IDLE)) begin
        complete     = 1'b1;
        frame_done_d = 1'b1;
        state_d      = ST_IDLE;
      end
    end else if (!enable && state_q != ST_IDLE && (!mwrite_q || !master_waitrequest)) begin
      // Disabled mid-frame: leave once the last pending write has been taken.
      state_d = ST_IDLE;
    end
  end

  // Sequencer and master-port registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      x_off_q      <= '0;
      line_base_q  <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      mwrite_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      x_off_q      <= x_off_d;
      line_base_q  <= line_base_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      mwrite_q     <= mwrite_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign master_address   = addr_q;
  assign master_writedata = data_q;
  assign master_write     = mwrite_q;
  assign frame_done       = frame_done_q;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pixel_stream_frame_dma.sv
// Directed bench for pixel_stream_frame_dma on a 4x2 frame of 16-bit pixels.
module tb_pixel_stream_frame_dma;

  localparam int FW = 4;
  localparam int FH = 2;
  localparam int PW = 16;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [PW-1:0] stream_data = '0;
  logic          stream_startofpacket = 1'b0;
  logic          stream_endofpacket = 1'b0;
  logic          stream_valid = 1'b0;
  logic          stream_ready;
  logic [AW-1:0] master_address;
  logic          master_write;
  logic [PW-1:0] master_writedata;
  logic          master_waitrequest = 1'b0;
  logic [1:0]    slave_address = '0;
  logic [3:0]    slave_byteenable = '0;
  logic          slave_read = 1'b0;
  logic          slave_write = 1'b0;
  logic [31:0]   slave_writedata = '0;
  logic [31:0]   slave_readdata;
  logic          frame_done;
  logic          busy;

  always #5 clk = ~clk;

  pixel_stream_frame_dma #(
    .FRAME_W (FW),
    .FRAME_H (FH),
    .PIX_W   (PW),
    .ADDR_W  (AW)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .stream_data          (stream_data),
    .stream_startofpacket (stream_startofpacket),
    .stream_endofpacket   (stream_endofpacket),
    .stream_valid         (stream_valid),
    .stream_ready         (stream_ready),
    .master_address       (master_address),
    .master_write         (master_write),
    .master_writedata     (master_writedata),
    .master_waitrequest   (master_waitrequest),
    .slave_address        (slave_address),
    .slave_byteenable     (slave_byteenable),
    .slave_read           (slave_read),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .slave_readdata       (slave_readdata),
    .frame_done           (frame_done),
    .busy                 (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Completed memory writes and frame_done pulses, sampled mid-cycle.
  logic [31:0] wr_addr[$];
  logic [15:0] wr_data[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (master_write && !master_waitrequest) begin
        wr_addr.push_back(master_address);
        wr_data.push_back(master_writedata);
      end
      if (frame_done) done_cnt++;
    end
  end

  logic [15:0] stim[16];
  logic [31:0] exp_addr[16];
  logic [15:0] exp_data[16];
  int          exp_n;
  int          exp_done = 0;
  logic [31:0] rd;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    slave_address    = a;
    slave_writedata  = d;
    slave_byteenable = be;
    slave_write      = 1'b1;
    step();
    slave_write      = 1'b0;
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
    slave_address = a;
    slave_read    = 1'b1;
    step();
    slave_read    = 1'b0;
    d             = slave_readdata;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic sop, input logic eop);
    int n;
    n                    = 0;
    stream_data          = d;
    stream_startofpacket = sop;
    stream_endofpacket   = eop;
    stream_valid         = 1'b1;
    @(negedge clk);
    while (!stream_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!stream_ready) check("ready_timeout", {31'b0, stream_ready}, 32'd1);
    step();
    stream_valid         = 1'b0;
    stream_startofpacket = 1'b0;
    stream_endofpacket   = 1'b0;
  endtask

  task automatic send_seq(input int n, input bit sop_first, input bit eop_last);
    for (int i = 0; i < n; i++) send_beat(stim[i], sop_first && i == 0, eop_last && i == n - 1);
  endtask

  // Expected addresses of pixels 0..n-1 placed from index start.
  task automatic expect_grid(input logic [31:0] front, input logic [31:0] stride,
                             input int n, input int start);
    for (int i = 0; i < n; i++) exp_addr[start + i] = front + (i / FW) * stride + (i % FW) * 2;
  endtask

  task automatic check_writes(input string tag);
    int n;
    repeat (4) step();
    check($sformatf("%s_count", tag), wr_addr.size(), exp_n);
    n = (wr_addr.size() < exp_n) ? wr_addr.size() : exp_n;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_addr[i], exp_addr[i]);
      check($sformatf("%s_data%0d", tag, i), {16'b0, wr_data[i]}, {16'b0, exp_data[i]});
    end
    check($sformatf("%s_frame_done", tag), done_cnt, exp_done);
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    longint      t0, t1;
    int          waited, base;
    logic [31:0] hold_a;
    logic [15:0] hold_d;

    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset state.
    check("rst_ready", {31'b0, stream_ready}, 32'd0);
    check("rst_write", {31'b0, master_write}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, frame_done}, 32'd0);
    reg_rd(2'd0, rd); check("rst_front", rd, 32'h0);
    reg_rd(2'd1, rd); check("rst_back", rd, 32'h0);
    reg_rd(2'd3, rd); check("rst_status", rd, 32'h0);

    // Arm a swap to back=0x1000; frame A still lands at front=0.
    reg_wr(2'd2, 32'h0000_0001, 4'hF);
    check("en_ready", {31'b0, stream_ready}, 32'd1);
    reg_wr(2'd1, 32'h0000_1000, 4'hF);
    reg_wr(2'd0, 32'hDEAD_BEEF, 4'hF);
    reg_rd(2'd3, rd); check("armed_status", rd, 32'h0000_0005);
    reg_rd(2'd0, rd); check("armed_front", rd, 32'h0);
    for (int i = 0; i < 8; i++) begin stim[i] = 16'h00A0 + 16'(i); exp_data[i] = stim[i]; end
    expect_grid(32'h0, 32'd8, 8, 0); exp_n = 8; exp_done = 1;
    send_seq(8, 1, 1);
    check_writes("a");
    reg_rd(2'd0, rd); check("a_front", rd, 32'h0000_1000);
    reg_rd(2'd1, rd); check("a_back", rd, 32'h0);
    reg_rd(2'd3, rd); check("a_status", rd, 32'h0001_0001);

    // Frame B: default stride, contiguous 0x1000..0x100E, one pixel per cycle.
    for (int i = 0; i < 8; i++) begin stim[i] = 16'h0100 + 16'(i); exp_data[i] = stim[i]; end
    expect_grid(32'h1000, 32'd8, 8, 0); exp_n = 8; exp_done = 2;
    t0 = $time;
    send_seq(8, 1, 1);
    t1 = $time;
    check("b_cycles", 32'((t1 - t0) / 10), 32'd8);
    check_writes("b");

    // Frame C: stride 16, second line starts at 0x1010.
    reg_wr(2'd2, 32'h0010_0001, 4'hF);
    for (int i = 0; i < 8; i++) begin stim[i] = 16'h0150 + 16'(i); exp_data[i] = stim[i]; end
    expect_grid(32'h1000, 32'd16, 8, 0); exp_n = 8; exp_done = 3;
    send_seq(8, 1, 1);
    check_writes("c");

    // Frame D: waitrequest held high for 5 cycles after the third write.
    for (int i = 0; i < 8; i++) begin stim[i] = 16'h0200 + 16'(i); exp_data[i] = stim[i]; end
    expect_grid(32'h1000, 32'd16, 8, 0); exp_n = 8; exp_done = 4;
    fork
      send_seq(8, 1, 1);
      begin
        waited = 0;
        base   = wr_addr.size();
        while (wr_addr.size() < base + 3 && waited < 100) begin
          step();
          waited++;
        end
        check("d_stall_reached", wr_addr.size(), base + 3);
        master_waitrequest = 1'b1;
        hold_a = master_address;
        hold_d = master_writedata;
        check("d_hold_addr_expected", hold_a, exp_addr[wr_addr.size()]);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check($sformatf("d_ready_low%0d", k), {31'b0, stream_ready}, 32'd0);
          check($sformatf("d_write_high%0d", k), {31'b0, master_write}, 32'd1);
          check($sformatf("d_addr_stable%0d", k), master_address, hold_a);
          check($sformatf("d_data_stable%0d", k), {16'b0, master_writedata}, {16'b0, hold_d});
        end
        step();
        master_waitrequest = 1'b0;
      end
    join
    check_writes("d");

    // Frame F: MASK against 0x0100.
    reg_wr(2'd3, 32'h0000_0100, 4'hF);
    reg_wr(2'd2, 32'h0010_0005, 4'hF);
    stim[0] = 16'h00FF; exp_data[0] = 16'h0000;
    stim[1] = 16'h0100; exp_data[1] = 16'hFFFF;
    stim[2] = 16'h0101; exp_data[2] = 16'hFFFF;
    stim[3] = 16'hFFFF; exp_data[3] = 16'hFFFF;
    stim[4] = 16'h0000; exp_data[4] = 16'h0000;
    stim[5] = 16'h00FF; exp_data[5] = 16'h0000;
    stim[6] = 16'h0100; exp_data[6] = 16'hFFFF;
    stim[7] = 16'h1234; exp_data[7] = 16'hFFFF;
    expect_grid(32'h1000, 32'd16, 8, 0); exp_n = 8; exp_done = 5;
    send_seq(8, 1, 1);
    check_writes("f");

    // Frame G: 12 beats into an 8-pixel frame; the tail is dropped, EOP completes.
    reg_wr(2'd2, 32'h0010_0001, 4'hF);
    for (int i = 0; i < 12; i++) stim[i] = 16'h0300 + 16'(i);
    for (int i = 0; i < 8; i++) exp_data[i] = stim[i];
    expect_grid(32'h1000, 32'd16, 8, 0); exp_n = 8; exp_done = 6;
    send_seq(11, 1, 0);
    check("g_busy_drain", {31'b0, busy}, 32'd1);
    send_beat(stim[11], 1'b0, 1'b1);
    check_writes("g");
    check("g_busy_after", {31'b0, busy}, 32'd0);

    // Frame H: FILL; SOP after 3 pixels restarts at 0x1000 without completing.
    reg_wr(2'd2, 32'h0010_0003, 4'hF);
    for (int i = 0; i < 11; i++) exp_data[i] = 16'h0100;
    for (int i = 0; i < 8; i++) stim[i] = 16'h7000 + 16'(i);
    expect_grid(32'h1000, 32'd16, 3, 0);
    expect_grid(32'h1000, 32'd16, 8, 3); exp_n = 11; exp_done = 7;
    send_seq(3, 1, 0);
    send_seq(8, 1, 1);
    check_writes("h");

    // Enable cleared mid-frame: writes already taken finish, state returns to idle.
    reg_wr(2'd2, 32'h0010_0001, 4'hF);
    for (int i = 0; i < 3; i++) begin stim[i] = 16'h0400 + 16'(i); exp_data[i] = stim[i]; end
    expect_grid(32'h1000, 32'd16, 3, 0); exp_n = 3;
    send_seq(3, 1, 0);
    check("dis_busy_before", {31'b0, busy}, 32'd1);
    reg_wr(2'd2, 32'h0010_0000, 4'hF);
    step(); step();
    check("dis_busy_after", {31'b0, busy}, 32'd0);
    check("dis_ready", {31'b0, stream_ready}, 32'd0);
    check_writes("dis");

    // Byte-enable on the back-address register.
    reg_wr(2'd1, 32'hAABB_CCDD, 4'b0101);
    reg_rd(2'd1, rd); check("be_back", rd, 32'h00BB_00DD);

    // Frame E: swap to back=0x2000.
    reg_wr(2'd2, 32'h0010_0001, 4'hF);
    reg_wr(2'd1, 32'h0000_2000, 4'hF);
    reg_wr(2'd0, 32'h0, 4'hF);
    for (int i = 0; i < 8; i++) begin stim[i] = 16'h0500 + 16'(i); exp_data[i] = stim[i]; end
    expect_grid(32'h1000, 32'd16, 8, 0); exp_n = 8; exp_done = 8;
    send_seq(8, 1, 1);
    check_writes("e");
    reg_rd(2'd0, rd); check("e_front", rd, 32'h0000_2000);
    reg_rd(2'd1, rd); check("e_back", rd, 32'h0000_1000);
    reg_rd(2'd3, rd); check("e_status", rd, 32'h0008_0001);

    // Reset wins over a write stalled by waitrequest.
    master_waitrequest = 1'b1;
    send_beat(16'h0055, 1'b1, 1'b0);
    check("rw_write_pending", {31'b0, master_write}, 32'd1);
    check("rw_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    step();
    check("rw_write_cleared", {31'b0, master_write}, 32'd0);
    check("rw_busy_cleared", {31'b0, busy}, 32'd0);
    check("rw_ready_cleared", {31'b0, stream_ready}, 32'd0);
    reset = 1'b0;
    master_waitrequest = 1'b0;
    reg_rd(2'd2, rd); check("rw_ctrl", rd, 32'h0);
    reg_rd(2'd0, rd); check("rw_front", rd, 32'h0);
    reg_rd(2'd3, rd); check("rw_status", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
